// File: rtl/lpc_sample_restorer.sv
// LPC sample restorer: rebuilds PCM samples from quantized coefficients, warm-up words and
// residuals using a single sequential multiply-accumulate, one tap per cycle.
module lpc_sample_restorer #(
    parameter int unsigned MAX_ORDER = 12,
    parameter int unsigned SAMPLE_W  = 16,
    parameter int unsigned COEFF_W   = 15,
    parameter int unsigned RES_W     = 24,
    parameter int unsigned ACC_W     = 40
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iEnable,
    input  logic                iStart,
    input  logic [3:0]          iOrder,
    input  logic [4:0]          iShift,
    input  logic [15:0]         iBlockSize,
    input  logic [COEFF_W-1:0]  iCoeff,
    input  logic                iCoeffValid,
    input  logic [RES_W-1:0]    iResidual,
    input  logic                iResidualValid,
    output logic                oReady,
    output logic [SAMPLE_W-1:0] oSample,
    output logic                oValid,
    output logic                oDone,
    output logic                oError
);

    localparam int unsigned PROD_W = COEFF_W + SAMPLE_W;

    typedef enum logic [2:0] {
        StIdle,
        StLoadCoef,
        StWarmup,
        StWait,
        StMac,
        StOut,
        StFinish
    } state_e;

    state_e                     state_q;
    logic [3:0]                 order_q;
    logic [4:0]                 shift_q;
    logic [15:0]                block_size_q;
    logic [15:0]                count_q;
    logic [3:0]                 tap_q;
    logic signed [COEFF_W-1:0]  qlp_q  [MAX_ORDER];
    logic signed [SAMPLE_W-1:0] hist_q [MAX_ORDER];
    logic signed [RES_W-1:0]    residual_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic                       ready_q;
    logic [SAMPLE_W-1:0]        sample_q;
    logic                       valid_q;
    logic                       done_q;
    logic                       error_q;

    logic                       accept;
    logic [15:0]                count_inc;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    res_ext;
    logic signed [ACC_W-1:0]    restored;
    logic [SAMPLE_W-1:0]        new_sample;

    always_comb begin
        accept     = iResidualValid & ready_q;
        count_inc  = count_q + 16'd1;
        prod       = qlp_q[tap_q] * hist_q[tap_q];
        prod_ext   = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        res_ext    = {{(ACC_W - RES_W){residual_q[RES_W-1]}}, residual_q};
        restored   = res_ext + (acc_q >>> shift_q);
        // Two's-complement wrap into the sample width, no saturation.
        new_sample = restored[SAMPLE_W-1:0];
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q      <= StIdle;
            order_q      <= '0;
            shift_q      <= '0;
            block_size_q <= '0;
            count_q      <= '0;
            tap_q        <= '0;
            residual_q   <= '0;
            acc_q        <= '0;
            ready_q      <= 1'b0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            for (int k = 0; k < int'(MAX_ORDER); k++) begin
                qlp_q[k]  <= '0;
                hist_q[k] <= '0;
            end
        end else if (iEnable) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b0;
                    if (iStart) begin
                        if (iOrder > 4'(MAX_ORDER)) begin
                            error_q <= 1'b1;
                        end else begin
                            order_q      <= iOrder;
                            shift_q      <= iShift;
                            block_size_q <= iBlockSize;
                            count_q      <= '0;
                            tap_q        <= '0;
                            if (iOrder != 4'd0) begin
                                state_q <= StLoadCoef;
                            end else if (iBlockSize == 16'd0) begin
                                state_q <= StFinish;
                            end else begin
                                state_q <= StWait;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                end
                StLoadCoef: begin
                    if (iCoeffValid) begin
                        qlp_q[tap_q] <= iCoeff;
                        if (tap_q == order_q - 4'd1) begin
                            tap_q <= '0;
                            if (block_size_q == 16'd0) begin
                                state_q <= StFinish;
                            end else begin
                                state_q <= StWarmup;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            tap_q <= tap_q + 4'd1;
                        end
                    end
                end
                // Warm-up words pass through StOut with a cleared accumulator.
                StWarmup: begin
                    if (accept) begin
                        residual_q <= iResidual;
                        acc_q      <= '0;
                        ready_q    <= 1'b0;
                        state_q    <= StOut;
                    end
                end
                StWait: begin
                    if (accept) begin
                        residual_q <= iResidual;
                        acc_q      <= '0;
                        tap_q      <= '0;
                        ready_q    <= 1'b0;
                        state_q    <= (order_q == 4'd0) ? StOut : StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + prod_ext;
                    if (tap_q == order_q - 4'd1) begin
                        tap_q   <= '0;
                        state_q <= StOut;
                    end else begin
                        tap_q <= tap_q + 4'd1;
                    end
                end
                StOut: begin
                    sample_q  <= new_sample;
                    valid_q   <= 1'b1;
                    hist_q[0] <= new_sample;
                    for (int k = 1; k < int'(MAX_ORDER); k++) begin
                        hist_q[k] <= hist_q[k-1];
                    end
                    count_q <= count_inc;
                    if (count_inc == block_size_q) begin
                        state_q <= StFinish;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= (count_inc < {12'd0, order_q}) ? StWarmup : StWait;
                    end
                end
                StFinish: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign oReady  = ready_q;
    assign oSample = sample_q;
    assign oValid  = valid_q;
    assign oDone   = done_q;
    assign oError  = error_q;

endmodule

// File: tb/tb_lpc_sample_restorer.sv
// Directed bench for lpc_sample_restorer: table of whole blocks plus hand-written sequences
// for error, held strobe, enable freeze and mid-block reset.
module tb_lpc_sample_restorer;

    logic        clk = 1'b0;
    logic        iReset, iEnable, iStart, iCoeffValid, iResidualValid;
    logic [3:0]  iOrder;
    logic [4:0]  iShift;
    logic [15:0] iBlockSize;
    logic [14:0] iCoeff;
    logic [23:0] iResidual;
    logic        oReady, oValid, oDone, oError;
    logic [15:0] oSample;

    always #5 clk = ~clk;

    lpc_sample_restorer dut (
        .iClock        (clk),
        .iReset        (iReset),
        .iEnable       (iEnable),
        .iStart        (iStart),
        .iOrder        (iOrder),
        .iShift        (iShift),
        .iBlockSize    (iBlockSize),
        .iCoeff        (iCoeff),
        .iCoeffValid   (iCoeffValid),
        .iResidual     (iResidual),
        .iResidualValid(iResidualValid),
        .oReady        (oReady),
        .oSample       (oSample),
        .oValid        (oValid),
        .oDone         (oDone),
        .oError        (oError)
    );

    typedef struct {
        int order;
        int shift;
        int bs;
        int coef[4];
        int nw;
        int w[4];
        int e[4];
    } vec_t;

    vec_t vecs[8];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   got_val[$];
    int   got_cyc[$];
    int   done_cnt = 0;
    int   err_cnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sample on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (oValid) begin
            got_val.push_back(int'($signed(oSample)));
            got_cyc.push_back(cyc);
        end
        if (oDone) done_cnt++;
        if (oError) err_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic start_block(input vec_t v);
        iStart     = 1'b1;
        iOrder     = 4'(v.order);
        iShift     = 5'(v.shift);
        iBlockSize = 16'(v.bs);
        @(negedge clk);
        iStart = 1'b0;
        for (int i = 0; i < v.order; i++) begin
            iCoeff      = 15'(v.coef[i]);
            iCoeffValid = 1'b1;
            @(negedge clk);
        end
        iCoeffValid = 1'b0;
    endtask

    task automatic send_res(input int v, output int acc_edge);
        int t = 0;
        acc_edge = -1;
        while (!oReady && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!oReady) begin
            check("ready_timeout", 0, 1);
        end else begin
            iResidual      = 24'(v);
            iResidualValid = 1'b1;
            acc_edge       = cyc + 1;
            @(negedge clk);
            iResidualValid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int base);
        int t = 0;
        while (done_cnt == base && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        check(name, done_cnt - base, 1);
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int   gbase;
        int   dbase;
        int   acc[4];
        int   lat;
        v     = vecs[k];
        gbase = got_val.size();
        dbase = done_cnt;
        start_block(v);
        for (int i = 0; i < v.nw; i++) send_res(v.w[i], acc[i]);
        wait_done($sformatf("v%0d_done", k), dbase);
        check($sformatf("v%0d_count", k), got_val.size() - gbase, v.nw);
        for (int i = 0; i < v.nw; i++) begin
            if (gbase + i < got_val.size()) begin
                lat = (i < v.order || v.order == 0) ? 1 : v.order + 1;
                check($sformatf("v%0d_sample%0d", k, i), got_val[gbase+i], v.e[i]);
                check($sformatf("v%0d_latency%0d", k, i), got_cyc[gbase+i] - acc[i], lat);
            end
        end
    endtask

    initial begin
        int a0, a1, a2, gbase, dbase, ebase, t;

        vecs[0] = '{1, 0, 4, '{1, 0, 0, 0}, 4, '{100, 5, 5, -3}, '{100, 105, 110, 107}};
        vecs[1] = '{2, 0, 4, '{2, -1, 0, 0}, 4, '{10, 20, 0, 0}, '{10, 20, 30, 40}};
        vecs[2] = '{1, 1, 2, '{3, 0, 0, 0}, 2, '{10, 0, 0, 0}, '{10, 15, 0, 0}};
        vecs[3] = '{1, 1, 2, '{3, 0, 0, 0}, 2, '{-7, 0, 0, 0}, '{-7, -11, 0, 0}};
        vecs[4] = '{1, 0, 2, '{1, 0, 0, 0}, 2, '{32767, 1, 0, 0}, '{32767, -32768, 0, 0}};
        vecs[5] = '{0, 0, 3, '{0, 0, 0, 0}, 3, '{7, -2, 40000, 0}, '{7, -2, -25536, 0}};
        vecs[6] = '{2, 0, 1, '{5, 6, 0, 0}, 1, '{9, 0, 0, 0}, '{9, 0, 0, 0}};
        vecs[7] = '{2, 0, 0, '{1, 1, 0, 0}, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}};

        iReset = 1'b1; iEnable = 1'b1; iStart = 1'b0; iOrder = '0; iShift = '0;
        iBlockSize = '0; iCoeff = '0; iCoeffValid = 1'b0; iResidual = '0; iResidualValid = 1'b0;
        repeat (3) @(negedge clk);
        iReset = 1'b0;
        check("rst_ready", int'(oReady), 0);
        check("rst_valid", int'(oValid), 0);
        check("rst_sample", int'(oSample), 0);
        check("rst_done", int'(oDone), 0);
        check("rst_error", int'(oError), 0);

        for (int k = 0; k < 8; k++) run_vec(k);

        // Illegal order: one error pulse, block machine stays idle.
        ebase = err_cnt;
        iStart = 1'b1; iOrder = 4'd13; iBlockSize = 16'd4;
        @(negedge clk);
        iStart = 1'b0;
        check("err_pulse", int'(oError), 1);
        check("err_ready", int'(oReady), 0);
        @(negedge clk);
        check("err_pulse_end", int'(oError), 0);
        check("err_count", err_cnt - ebase, 1);
        run_vec(0);

        // Residual strobe held high through the MAC: one sample per accept.
        gbase = got_val.size();
        dbase = done_cnt;
        start_block(vecs[1]);
        send_res(10, a0);
        send_res(20, a1);
        iResidual = '0; iResidualValid = 1'b1;
        wait_done("hold_done", dbase);
        iResidualValid = 1'b0;
        check("hold_count", got_val.size() - gbase, 4);
        if (got_val.size() - gbase == 4) begin
            check("hold_s2", got_val[gbase+2], 30);
            check("hold_s3", got_val[gbase+3], 40);
        end

        // Enable dropped for three edges mid-MAC: same value, three cycles later.
        gbase = got_val.size();
        dbase = done_cnt;
        start_block(vecs[1]);
        send_res(10, a0);
        send_res(20, a1);
        send_res(0, a2);
        iEnable = 1'b0;
        repeat (3) @(negedge clk);
        iEnable = 1'b1;
        send_res(0, a0);
        wait_done("freeze_done", dbase);
        check("freeze_count", got_val.size() - gbase, 4);
        if (got_val.size() - gbase == 4) begin
            check("freeze_s2", got_val[gbase+2], 30);
            check("freeze_lat", got_cyc[gbase+2] - a2, 6);
            check("freeze_s3", got_val[gbase+3], 40);
        end

        // Reset in the middle of the MAC aborts the block without oDone.
        start_block(vecs[1]);
        send_res(10, a0);
        send_res(20, a1);
        send_res(0, a2);
        gbase = got_val.size();
        dbase = done_cnt;
        iReset = 1'b1;
        @(negedge clk);
        iReset = 1'b0;
        check("mrst_ready", int'(oReady), 0);
        check("mrst_valid", int'(oValid), 0);
        check("mrst_sample", int'(oSample), 0);
        check("mrst_done", int'(oDone), 0);
        t = 0;
        while (t < 12) begin
            @(negedge clk);
            t++;
        end
        check("mrst_no_done", done_cnt - dbase, 0);
        check("mrst_no_sample", got_val.size() - gbase, 0);
        check("mrst_idle_ready", int'(oReady), 0);
        run_vec(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lpc_sample_restorer.md
Name: lpc_sample_restorer

Overview:
- Decoder-side counterpart of the encoder's LPC analysis path: rebuilds PCM samples from quantized LPC coefficients, warm-up samples and residuals.
- Implements FLAC LPC restoration: sample[n] = residual[n] + ((sum_j qlp[j]*sample[n-1-j]) >>> shift).
- Consumes one block at a time and uses one sequential multiply-accumulate (MAC), one coefficient per cycle.
- Feeds the bench-side reconstruction check and the future hardware decoder.

Parameters:
- MAX_ORDER, 12, maximum predictor order supported.
- SAMPLE_W, 16, PCM sample width (signed).
- COEFF_W, 15, quantized coefficient width (signed).
- RES_W, 24, residual/warm-up input width (signed).
- ACC_W, 40, accumulator width (signed).

Ports:
- iClock  in  1  clock.
- iReset  in  1  synchronous active-high reset.
- iEnable  in  1  clock enable; low freezes all state and outputs.
- iStart  in  1  one-cycle pulse in S_IDLE; latches iOrder, iShift, iBlockSize.
- iOrder  in  4  predictor order, 0..MAX_ORDER.
- iShift  in  5  quantization shift, 0..15.
- iBlockSize  in  16  total samples in the block, including warm-up.
- iCoeff  in  COEFF_W  quantized coefficient word.
- iCoeffValid  in  1  coefficient strobe.
- iResidual  in  RES_W  warm-up sample or residual.
- iResidualValid  in  1  residual/warm-up strobe.
- oReady  out  1  block accepts iResidual this cycle.
- oSample  out  SAMPLE_W  reconstructed sample.
- oValid  out  1  oSample valid, one-cycle pulse per sample.
- oDone  out  1  one-cycle pulse after the last sample of the block.
- oError  out  1  one-cycle pulse when iStart carries iOrder > MAX_ORDER.

Behaviour:
- Reset: all outputs 0; state S_IDLE; history, coefficients, accumulator and counters cleared. Reset mid-block aborts immediately; no oDone is produced.
- All activity is qualified by iEnable. Transfers and state transitions occur only on edges where iEnable=1.
- States:
  - S_IDLE: oReady=0. On iStart:
    - iOrder > MAX_ORDER: pulse oError, stay in S_IDLE.
    - iOrder = 0: go to S_WAIT.
    - otherwise: go to S_LOAD_COEF.
  - S_LOAD_COEF: each iCoeffValid stores iCoeff into qlp[idx], idx = 0, 1, .... After iOrder words, go to S_WARMUP. iResidualValid is ignored here.
  - S_WARMUP: oReady=1. Each accepted word (iResidualValid & oReady) is truncated to SAMPLE_W and pushed into the history. It is output on the next cycle (oValid=1, latency 1). After iOrder words, go to S_WAIT. If the sample count reaches iBlockSize first, go to S_FINISH.
  - S_WAIT: oReady=1. An accepted residual is latched, the accumulator is cleared, and the state goes to S_MAC. oReady=0 from the next cycle until the sample is output.
  - S_MAC: one cycle per tap, j = 0..iOrder-1: acc += qlp[j]*hist[j], where hist[0] is the most recent sample. Products are sign-extended to ACC_W.
  - S_OUT: sample = residual + (acc >>> iShift), arithmetic shift. The result is truncated to the low SAMPLE_W bits (two's-complement wrap, no saturation). It is registered to oSample with oValid=1 for one cycle, and pushed into the history (hist[k] <= hist[k-1]). Next state is S_WAIT, or S_FINISH if count = iBlockSize.
  - S_FINISH: oDone=1 for one cycle, then S_IDLE.
- Latency:
  - Warm-up: oValid one cycle after the accept edge.
  - Residual: oValid iOrder+1 cycles after the accept edge.
  - Order 0: oValid one cycle after the accept edge, with sample = residual truncated.
- Throughput: one sample per iOrder+2 cycles, or per 2 cycles for order 0 and warm-up.
- Ignored inputs:
  - iResidualValid while oReady=0: ignored, not buffered.
  - iStart outside S_IDLE: ignored.
  - iCoeffValid outside S_LOAD_COEF: ignored.
- iBlockSize=0: S_FINISH directly after the configuration completes (coefficients loaded, or immediately for order 0).
- History entries beyond iOrder are never read.
- oSample holds its last value while oValid=0.

Test Plan:
- Order 1, qlp=[1], shift 0, blocksize 4; warm-up 100; residuals 5, 5, -3 -> oSample 100, 105, 110, 107, then one oDone pulse.
- Order 2, qlp=[2,-1], shift 0; warm-up 10, 20; residuals 0, 0 -> 10, 20, 30, 40. Each residual oValid arrives exactly 3 cycles after its accept edge.
- Shift case: order 1, qlp=[3], shift 1.
  - Warm-up 10, residual 0 -> 15.
  - New block with warm-up -7, residual 0 -> -11 (arithmetic floor).
- Wrap case: order 1, qlp=[1]; warm-up 32767, residual 1 -> -32768.
- Order 0, blocksize 3; residuals 7, -2, 40000 -> 7, -2, -25536 (truncated). iStart with iOrder=13 -> oError pulse and no state change.
- Control robustness:
  - Hold iResidualValid=1 through S_MAC -> exactly one sample per accept.
  - Drop iEnable mid-MAC -> result unchanged but delayed.
  - Assert iReset mid-MAC -> all outputs 0, S_IDLE, no oDone.
